// File: rtl/axis_ad5791_cfg_sequencer.sv
// Configuration master for the AD5791 quad SPI serializer.
// Holds the serializer in configuration mode, loads one raw 24-bit register
// word per channel for each init step, triggers one SPI frame per step via the
// send/ready handshake, then returns the serializer to streaming mode.
// Optional build macro AD5791_CFG_MIDSCALE_EN adds a third step that writes
// the DAC register with midscale (0x180000, 0 V in offset binary).
module axis_ad5791_cfg_sequencer #(
    parameter int NUM_DAC           = 4,
    parameter int DAC_WORD_WIDTH    = 24,
    parameter int SAXIS_TDATA_WIDTH = 32,
    parameter int START_TIMEOUT     = 256,
    parameter int XFER_TIMEOUT      = 4096,
    parameter int GAP_CYCLES        = 64
) (
    input  logic                         a_clk,
    input  logic                         a_resetn,
    input  logic                         init_start,
    input  logic [19:0]                  ctrl_bits,
    input  logic [19:0]                  clearcode,
    input  logic                         ready_in,
    output logic [SAXIS_TDATA_WIDTH-1:0] M_AXISCFG_tdata,
    output logic                         M_AXISCFG_tvalid,
    output logic                         configuration_mode,
    output logic [2:0]                   configuration_axis,
    output logic                         configuration_send,
    output logic                         busy,
    output logic                         done,
    output logic                         nochange,
    output logic                         error
);

`ifdef AD5791_CFG_MIDSCALE_EN
    localparam int NUM_STEPS = 3;
`else
    localparam int NUM_STEPS = 2;
`endif

    localparam int CNT_MAX_A = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_XFER,
        S_RELEASE,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          axis_q, axis_d;
    logic [1:0]          step_q, step_d;
    logic [19:0]         ctrl_q, ctrl_d;
    logic [19:0]         clear_q, clear_d;
    logic                nochange_q, nochange_d;
    logic                error_q, error_d;
    logic                init_q;
    logic                start;
    logic [DAC_WORD_WIDTH-1:0] cfg_word;

    assign start              = init_start & ~init_q;
    assign configuration_axis = axis_q;
    assign nochange           = nochange_q;
    assign error              = error_q;

    // Raw register word for the current step: {R/W=0, address, payload}.
    always_comb begin
        cfg_word = '0;
        case (step_q)
            2'd0:    cfg_word = DAC_WORD_WIDTH'({1'b0, 3'b010, ctrl_q});
            2'd1:    cfg_word = DAC_WORD_WIDTH'({1'b0, 3'b011, clear_q});
`ifdef AD5791_CFG_MIDSCALE_EN
            2'd2:    cfg_word = DAC_WORD_WIDTH'({1'b0, 3'b001, 20'h80000});
`endif
            default: cfg_word = '0;
        endcase
    end

    // Sequencer next-state logic and state-decoded outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        axis_d     = axis_q;
        step_d     = step_q;
        ctrl_d     = ctrl_q;
        clear_d    = clear_q;
        nochange_d = nochange_q;
        error_d    = error_q;

        M_AXISCFG_tdata    = '0;
        M_AXISCFG_tvalid   = 1'b0;
        configuration_mode = 1'b0;
        configuration_send = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ctrl_d     = ctrl_bits;
                    clear_d    = clearcode;
                    nochange_d = 1'b0;
                    error_d    = 1'b0;
                    step_d     = '0;
                    axis_d     = '0;
                    cnt_d      = '0;
                    state_d    = S_LOAD;
                end
            end

            S_LOAD: begin
                busy               = 1'b1;
                configuration_mode = 1'b1;
                M_AXISCFG_tvalid   = 1'b1;
                M_AXISCFG_tdata    = SAXIS_TDATA_WIDTH'(cfg_word);
                if (axis_q == 3'(NUM_DAC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SEND;
                end else begin
                    axis_d = axis_q + 3'd1;
                end
            end

            S_SEND: begin
                busy               = 1'b1;
                configuration_mode = 1'b1;
                configuration_send = 1'b1;
                if (!ready_in) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    // Serializer saw identical words and produced no frame.
                    nochange_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_XFER: begin
                busy               = 1'b1;
                configuration_mode = 1'b1;
                configuration_send = 1'b1;
                if (ready_in) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_W'(XFER_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RELEASE: begin
                busy               = 1'b1;
                configuration_mode = 1'b1;
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (step_q == 2'(NUM_STEPS - 1)) begin
                        state_d = S_FINISH;
                    end else begin
                        step_d  = step_q + 2'd1;
                        axis_d  = '0;
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge a_clk) begin
        if (!a_resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            axis_q     <= '0;
            step_q     <= '0;
            ctrl_q     <= '0;
            clear_q    <= '0;
            nochange_q <= 1'b0;
            error_q    <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            axis_q     <= axis_d;
            step_q     <= step_d;
            ctrl_q     <= ctrl_d;
            clear_q    <= clear_d;
            nochange_q <= nochange_d;
            error_q    <= error_d;
            init_q     <= init_start;
        end
    end

endmodule

// File: tb/tb_axis_ad5791_cfg_sequencer.sv
// Self-checking bench for axis_ad5791_cfg_sequencer with a behavioural
// serializer model and a step-level reference of the configuration sequence.
module tb_axis_ad5791_cfg_sequencer;

    localparam int NUM_DAC       = 4;
    localparam int START_TIMEOUT = 256;
    localparam int XFER_TIMEOUT  = 4096;
    localparam int GAP_CYCLES    = 64;
`ifdef AD5791_CFG_MIDSCALE_EN
    localparam int NUM_STEPS = 3;
`else
    localparam int NUM_STEPS = 2;
`endif

    logic        a_clk = 1'b0;
    logic        a_resetn;
    logic        init_start;
    logic [19:0] ctrl_bits;
    logic [19:0] clearcode;
    logic        ready_in;
    logic [31:0] M_AXISCFG_tdata;
    logic        M_AXISCFG_tvalid;
    logic        configuration_mode;
    logic [2:0]  configuration_axis;
    logic        configuration_send;
    logic        busy;
    logic        done;
    logic        nochange;
    logic        error;

    always #5 a_clk = ~a_clk;

    axis_ad5791_cfg_sequencer #(
        .NUM_DAC          (NUM_DAC),
        .DAC_WORD_WIDTH   (24),
        .SAXIS_TDATA_WIDTH(32),
        .START_TIMEOUT    (START_TIMEOUT),
        .XFER_TIMEOUT     (XFER_TIMEOUT),
        .GAP_CYCLES       (GAP_CYCLES)
    ) dut (
        .a_clk             (a_clk),
        .a_resetn          (a_resetn),
        .init_start        (init_start),
        .ctrl_bits         (ctrl_bits),
        .clearcode         (clearcode),
        .ready_in          (ready_in),
        .M_AXISCFG_tdata   (M_AXISCFG_tdata),
        .M_AXISCFG_tvalid  (M_AXISCFG_tvalid),
        .configuration_mode(configuration_mode),
        .configuration_axis(configuration_axis),
        .configuration_send(configuration_send),
        .busy              (busy),
        .done              (done),
        .nochange          (nochange),
        .error             (error)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- serializer model ----------------
    // Latches channel words while tvalid; on send it produces a frame only if
    // some channel word differs from what that register last received.
    logic [31:0] ser_cur [NUM_DAC];
    logic [31:0] ser_shadow [NUM_DAC][8];
    int          ser_st = 0;
    int          ser_cnt = 0;
    int          ser_frames = 0;
    bit          ser_stuck = 1'b0;
    bit          ser_abort = 1'b0;
    bit          ser_diff;

    initial begin
        ready_in = 1'b1;
        for (int unsigned ch = 0; ch < NUM_DAC; ch++) begin
            ser_cur[ch] = '0;
            for (int unsigned a = 0; a < 8; a++) ser_shadow[ch][a] = '1;
        end
        forever begin
            @(negedge a_clk);
            if (M_AXISCFG_tvalid && (configuration_axis < 3'(NUM_DAC)))
                ser_cur[configuration_axis[1:0]] = M_AXISCFG_tdata;
            if (ser_abort) begin
                ready_in  = 1'b1;
                ser_st    = 3;
                ser_abort = 1'b0;
            end
            case (ser_st)
                0: if (configuration_send && configuration_mode) begin
                    ser_diff = 1'b0;
                    for (int unsigned ch = 0; ch < NUM_DAC; ch++)
                        if (ser_cur[ch] != ser_shadow[ch][ser_cur[ch][22:20]]) ser_diff = 1'b1;
                    if (ser_diff) begin
                        ser_st  = 1;
                        ser_cnt = int'($urandom_range(1, 40));
                    end else begin
                        ser_st = 3;
                    end
                end
                1: begin
                    ser_cnt--;
                    if (ser_cnt <= 0) begin
                        ready_in = 1'b0;
                        ser_frames++;
                        ser_st  = 2;
                        ser_cnt = int'($urandom_range(5, 200));
                    end
                end
                2: if (!ser_stuck) begin
                    ser_cnt--;
                    if (ser_cnt <= 0) begin
                        ready_in = 1'b1;
                        for (int unsigned ch = 0; ch < NUM_DAC; ch++)
                            ser_shadow[ch][ser_cur[ch][22:20]] = ser_cur[ch];
                        ser_st = 3;
                    end
                end
                default: if (!configuration_send) ser_st = 0;
            endcase
        end
    end

    // ---------------- output monitor ----------------
    logic [34:0] mon_words[$];
    int          mon_runs[$];
    int          mon_gaps[$];
    int          done_cnt = 0;
    logic        done_noch, done_err;
    int          mb_err = 0;
    int          send_run = 0;
    int          gap_cnt = 0;
    bit          gap_active = 1'b0;
    bit          send_prev = 1'b0;

    initial begin
        forever begin
            @(negedge a_clk);
            if (M_AXISCFG_tvalid) mon_words.push_back({configuration_axis, M_AXISCFG_tdata});
            if (configuration_mode !== busy) mb_err++;
            if (gap_active) begin
                if (configuration_mode && !configuration_send && !M_AXISCFG_tvalid) gap_cnt++;
                else begin
                    mon_gaps.push_back(gap_cnt);
                    gap_active = 1'b0;
                end
            end
            if (configuration_send) send_run++;
            else if (send_prev) begin
                mon_runs.push_back(send_run);
                send_run = 0;
                if (configuration_mode) begin
                    gap_active = 1'b1;
                    gap_cnt    = 1;
                end
            end
            send_prev = configuration_send;
            if (done) begin
                done_cnt++;
                done_noch = nochange;
                done_err  = error;
            end
        end
    end

    // ---------------- reference ----------------
    logic [31:0] ref_last [8];

    task automatic clear_mon();
        mon_words.delete();
        mon_runs.delete();
        mon_gaps.delete();
        done_cnt   = 0;
        mb_err     = 0;
        send_run   = 0;
        gap_active = 1'b0;
        ser_frames = 0;
    endtask

    task automatic run_seq(input logic [19:0] c, input logic [19:0] cl, input bit stuck,
                           input bit toggle, input string nm);
        logic [23:0] w [3];
        logic [34:0] exp_words[$];
        int          exp_runs[$];
        bit          exp_noch = 1'b0;
        bit          exp_err = 1'b0;
        int          exp_frames = 0;
        int          exp_gaps = 0;
        int          t = 0;
        logic [2:0]  a;
        w[0] = {1'b0, 3'b010, c};
        w[1] = {1'b0, 3'b011, cl};
        w[2] = 24'h180000;
        for (int unsigned k = 0; k < NUM_STEPS; k++) begin
            a = w[k][22:20];
            for (int unsigned ax = 0; ax < NUM_DAC; ax++)
                exp_words.push_back({3'(ax), 8'h00, w[k]});
            if ({8'h00, w[k]} != ref_last[a]) begin
                exp_frames++;
                exp_runs.push_back(-1);
                if (stuck) begin
                    exp_err = 1'b1;
                    break;
                end
                ref_last[a] = {8'h00, w[k]};
                exp_gaps++;
            end else begin
                exp_noch = 1'b1;
                exp_runs.push_back(START_TIMEOUT);
                exp_gaps++;
            end
        end

        @(negedge a_clk);
        clear_mon();
        ser_stuck  = stuck;
        ctrl_bits  = c;
        clearcode  = cl;
        init_start = 1'b1;
        @(negedge a_clk);
        init_start = 1'b0;
        if (toggle) begin
            for (int unsigned i = 0; i < 5; i++) begin
                repeat (15) @(negedge a_clk);
                init_start = 1'b1;
                @(negedge a_clk);
                init_start = 1'b0;
            end
        end
        while (done_cnt == 0 && t < 20000) begin
            @(negedge a_clk);
            t++;
        end
        check_eq({nm, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
        repeat (20) @(negedge a_clk);
        check_eq({nm, "_done_once"}, 64'(done_cnt), 64'd1);
        check_eq({nm, "_busy_after"}, 64'(busy), 64'd0);
        check_eq({nm, "_mode_after"}, 64'(configuration_mode), 64'd0);
        check_eq({nm, "_nochange"}, 64'(done_noch), 64'(exp_noch));
        check_eq({nm, "_error"}, 64'(done_err), 64'(exp_err));
        check_eq({nm, "_frames"}, 64'(ser_frames), 64'(exp_frames));
        check_eq({nm, "_mode_eq_busy"}, 64'(mb_err), 64'd0);
        check_eq({nm, "_nwords"}, 64'(mon_words.size()), 64'(exp_words.size()));
        for (int unsigned i = 0; i < exp_words.size() && i < mon_words.size(); i++)
            check_eq({nm, "_word"}, 64'(mon_words[i]), 64'(exp_words[i]));
        check_eq({nm, "_nruns"}, 64'(mon_runs.size()), 64'(exp_runs.size()));
        for (int unsigned i = 0; i < exp_runs.size() && i < mon_runs.size(); i++)
            if (exp_runs[i] >= 0) check_eq({nm, "_send_len"}, 64'(mon_runs[i]), 64'(exp_runs[i]));
        check_eq({nm, "_ngaps"}, 64'(mon_gaps.size()), 64'(exp_gaps));
        for (int unsigned i = 0; i < mon_gaps.size(); i++)
            check_eq({nm, "_gap_len"}, 64'(mon_gaps[i]), 64'(GAP_CYCLES));
        if (stuck) begin
            ser_stuck = 1'b0;
            ser_abort = 1'b1;
            repeat (3) @(negedge a_clk);
        end
    endtask

    task automatic check_all_zero(input string nm);
        check_eq({nm, "_tdata"}, 64'(M_AXISCFG_tdata), 64'd0);
        check_eq({nm, "_tvalid"}, 64'(M_AXISCFG_tvalid), 64'd0);
        check_eq({nm, "_mode"}, 64'(configuration_mode), 64'd0);
        check_eq({nm, "_axis"}, 64'(configuration_axis), 64'd0);
        check_eq({nm, "_send"}, 64'(configuration_send), 64'd0);
        check_eq({nm, "_busy"}, 64'(busy), 64'd0);
        check_eq({nm, "_done"}, 64'(done), 64'd0);
        check_eq({nm, "_nochange"}, 64'(nochange), 64'd0);
        check_eq({nm, "_error"}, 64'(error), 64'd0);
    endtask

    initial begin
        logic [19:0] c;
        int          t;
        for (int unsigned a = 0; a < 8; a++) ref_last[a] = '1;
        a_resetn   = 1'b0;
        init_start = 1'b0;
        ctrl_bits  = '0;
        clearcode  = '0;
        repeat (3) @(posedge a_clk);
        #1;
        check_all_zero("reset");
        @(negedge a_clk);
        a_resetn = 1'b1;
        repeat (3) @(negedge a_clk);

        run_seq(20'h00012, 20'h80000, 1'b0, 1'b0, "basic");
        run_seq(20'h00012, 20'h80000, 1'b0, 1'b0, "ident");
        run_seq(20'($urandom), 20'($urandom), 1'b0, 1'b1, "toggle");
        run_seq(20'($urandom), 20'($urandom), 1'b0, 1'b0, "rand1");
        run_seq(20'($urandom), 20'($urandom), 1'b0, 1'b0, "rand2");
        run_seq(20'($urandom), 20'($urandom), 1'b1, 1'b0, "stuck");
        run_seq(20'($urandom), 20'($urandom), 1'b0, 1'b0, "after_err");

        // Reset while a frame is in flight.
        do c = 20'($urandom); while ({12'h002, c} == ref_last[2]);
        @(negedge a_clk);
        clear_mon();
        ctrl_bits  = c;
        clearcode  = 20'($urandom);
        init_start = 1'b1;
        @(negedge a_clk);
        init_start = 1'b0;
        t = 0;
        while (ser_st != 2 && t < 2000) begin
            @(negedge a_clk);
            t++;
        end
        check_eq("rst_reach_xfer", 64'(ser_st), 64'd2);
        repeat (3) @(negedge a_clk);
        check_eq("rst_in_xfer_send", 64'(configuration_send), 64'd1);
        a_resetn = 1'b0;
        @(posedge a_clk);
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge a_clk);
        a_resetn = 1'b1;
        t = 0;
        while (ser_st != 0 && t < 2000) begin
            @(negedge a_clk);
            t++;
        end
        check_eq("rst_ser_idle", 64'(ser_st), 64'd0);
        for (int unsigned a = 0; a < 8; a++) ref_last[a] = ser_shadow[0][a];

        run_seq(20'($urandom), 20'($urandom), 1'b0, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
